// File: rtl/uba_npr_arb.sv
// Round-robin arbiter sharing the UBA NPR engine's device request port among Unibus devices.
// Latches the winner's address/data, forwards one request, returns the ack, and watches for stuck grants.
module uba_npr_arb #(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_DEV-1:0]     devREQI,
  input  logic [36*NUM_DEV-1:0]  devADDRI,
  input  logic [36*NUM_DEV-1:0]  devDATAI,
  output logic [NUM_DEV-1:0]     devACKO,
  output logic                   nprREQO,
  output logic [35:0]            nprADDRO,
  output logic [35:0]            nprDATAO,
  input  logic                   nprACKI,
  output logic [2:0]             arbGNT,
  output logic                   errTIMEOUT,
  input  logic                   errCLR
);

  localparam int unsigned IdxW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam logic [15:0] WdLim = (TIMEOUT > 32'd65535) ? 16'hFFFF : 16'(TIMEOUT);
  localparam bit WdEn = (TIMEOUT != 0);
  localparam logic [NUM_DEV-1:0] OneDev = NUM_DEV'(1);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     ptr_q, gnt_q;
  logic                req_q, err_q;
  logic [NUM_DEV-1:0]  ack_q;
  logic [35:0]         addr_q, data_q;
  logic [15:0]         wd_q;

  logic                win;
  logic [IdxW-1:0]     win_idx, ptr_next;
  logic [35:0]         win_addr, win_data;
  logic [15:0]         wd_inc;
  logic                wd_hit;

  // First requester at or above the pointer, wrapping around, takes the grant.
  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_DEV; k++) begin
      logic [IdxW-1:0] idx;
      idx = IdxW'((32'(ptr_q) + k) % NUM_DEV);
      if (!win && devREQI[idx]) begin
        win     = 1'b1;
        win_idx = idx;
      end
    end
    win_addr = devADDRI[36*32'(win_idx) +: 36];
    win_data = devDATAI[36*32'(win_idx) +: 36];
    ptr_next = IdxW'((32'(gnt_q) + 32'd1) % NUM_DEV);
    wd_inc   = (&wd_q) ? wd_q : wd_q + 16'd1;
    // Fire only on the cycle the count reaches the limit, so a clear can stick afterwards.
    wd_hit   = WdEn && (wd_inc == WdLim) && (wd_q != WdLim);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      req_q   <= 1'b0;
      ack_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (errCLR) err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win) begin
            gnt_q   <= win_idx;
            addr_q  <= win_addr;
            data_q  <= win_data;
            req_q   <= 1'b1;
            wd_q    <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (nprACKI) begin
            req_q   <= 1'b0;
            ack_q   <= OneDev << gnt_q;
            ptr_q   <= ptr_next;
            state_q <= StRelease;
          end else begin
            wd_q <= wd_inc;
            if (wd_hit) err_q <= 1'b1;
          end
        end
        StRelease: begin
          ack_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign devACKO    = ack_q;
  assign nprREQO    = req_q;
  assign nprADDRO   = addr_q;
  assign nprDATAO   = data_q;
  assign arbGNT     = 3'(gnt_q);
  assign errTIMEOUT = err_q;

endmodule
